// File: rtl/log_softmax_pkg.sv
// rtl/log_softmax_pkg.sv - shared state type, fixed-point constants and helpers for log_softmax_stream
package log_softmax_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SUM  = 2'd1,
        LOG  = 2'd2,
        EMIT = 2'd3
    } lsm_state_t;

    localparam real LOG2E_R = 1.4426950408889634;
    localparam real LN2_R   = 0.6931471805599453;

    // round(log2(e) * 2^frac_w)
    function automatic int log2e_q(input int frac_w);
        return int'(LOG2E_R * real'(1 << frac_w));
    endfunction

    // round(ln(2) * 2^frac_w)
    function automatic int ln2_q(input int frac_w);
        return int'(LN2_R * real'(1 << frac_w));
    endfunction

    localparam int DEF_FRAC_W = 8;
    localparam int LOG2E_Q    = log2e_q(DEF_FRAC_W);
    localparam int LN2_Q      = ln2_q(DEF_FRAC_W);

    // Clamp a wide signed value into the signed range of a w-bit word
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/lsm_exp2_log2.sv
// rtl/lsm_exp2_log2.sv - combinational shift/linear exp2 term and Mitchell log2 approximation
module lsm_exp2_log2
    import log_softmax_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int SUM_W  = 15,
    parameter int L2_W   = 13
) (
    input  logic signed [DATA_W:0] d,
    output logic        [SUM_W-1:0] e,
    input  logic        [SUM_W-1:0] sum,
    output logic        [L2_W-1:0]  l2
);

    localparam int PROD_W = DATA_W + FRAC_W + 4;
    localparam int P_W    = $clog2(SUM_W);
    localparam int SH_W   = L2_W - FRAC_W;
    localparam logic signed [PROD_W-1:0] LOG2E_K = PROD_W'(log2e_q(FRAC_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] t;
    logic signed [PROD_W-1:0] k;
    logic        [PROD_W-1:0] neg_k;
    logic        [FRAC_W:0]   mant1;
    logic        [P_W-1:0]    p;
    logic        [P_W-1:0]    sh;
    logic        [SUM_W-1:0]  rem;
    logic        [SUM_W-1:0]  rem_sh;

    // exp(d) as 2^(d*log2e): integer part k becomes a right shift, fraction f a linear mantissa 1+f
    always_comb begin
        prod  = PROD_W'(d) * LOG2E_K;
        t     = prod >>> FRAC_W;
        k     = t >>> FRAC_W;
        neg_k = -k;
        mant1 = {1'b1, t[FRAC_W-1:0]};
        if (neg_k >= PROD_W'(SUM_W)) begin
            e = '0;
        end else begin
            e = SUM_W'(mant1) >> neg_k;
        end
    end

    // log2(sum) as leading-one position plus the bits below it read as a linear fraction
    always_comb begin
        p = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (sum[i]) p = P_W'(i);
        end
        sh     = p - P_W'(FRAC_W);
        rem    = sum;
        rem[p] = 1'b0;
        rem_sh = rem >> sh;
        l2     = {SH_W'(sh), FRAC_W'(rem_sh)};
    end

endmodule

// File: rtl/log_softmax_stream.sv
// rtl/log_softmax_stream.sv - single-buffered streaming LogSoftmax over tlast-delimited vectors
module log_softmax_stream
    import log_softmax_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int MAX_LEN = 64,
    parameter int SUM_W   = FRAC_W + 1 + $clog2(MAX_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     len_err
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = IDX_W + 1;
    localparam int L2_W  = FRAC_W + $clog2(SUM_W) + 1;
    localparam int LP_W  = L2_W + FRAC_W;
    localparam logic [LP_W-1:0] LN2_K = LP_W'(ln2_q(FRAC_W));

    lsm_state_t state;
    lsm_state_t state_n;

    logic signed [DATA_W-1:0] mem [MAX_LEN];
    logic        [CNT_W-1:0]  count;
    logic        [IDX_W-1:0]  idx;
    logic signed [DATA_W-1:0] max_q;
    logic        [SUM_W-1:0]  sum_q;
    logic        [L2_W-1:0]   lse_q;
    logic                     ready_en;

    logic                     in_hs;
    logic                     out_hs;
    logic                     trunc;
    logic                     last_in;
    logic                     last_idx;
    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W:0]   d;
    logic        [SUM_W-1:0]  e;
    logic        [L2_W-1:0]   l2;
    logic        [LP_W-1:0]   lse_prod;
    logic signed [31:0]       y_full;
    logic signed [31:0]       y_sat;

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    // The MAX_LEN-th element closes the vector even without in_last
    assign trunc    = (count == CNT_W'(MAX_LEN - 1)) & ~in_last;
    assign last_in  = in_last | trunc;
    assign last_idx = ({1'b0, idx} == (count - CNT_W'(1)));
    assign cur      = mem[idx];
    assign d        = {cur[DATA_W-1], cur} - {max_q[DATA_W-1], max_q};
    assign lse_prod = LP_W'(l2) * LN2_K;
    assign y_full   = 32'(cur) - 32'(max_q) - 32'($signed({1'b0, lse_q}));
    assign y_sat    = sat_signed(y_full, DATA_W);

    lsm_exp2_log2 #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .SUM_W  (SUM_W),
        .L2_W   (L2_W)
    ) u_exp2_log2 (
        .d   (d),
        .e   (e),
        .sum (sum_q),
        .l2  (l2)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    // Next-state decode plus input-side handshake and busy flag
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            LOAD: begin
                in_ready = ready_en;
                busy     = (count != '0);
                if (in_valid && ready_en && last_in) state_n = SUM;
            end
            SUM: begin
                if (last_idx) state_n = LOG;
            end
            LOG: begin
                state_n = EMIT;
            end
            EMIT: begin
                if (out_hs && out_last) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    // Element buffer; never cleared, only overwritten by the next vector
    always_ff @(posedge clk) begin
        if (!rst && in_hs) mem[IDX_W'(count)] <= in_data;
    end

    // Datapath: running max, exp-sum accumulation, lse register and the registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            idx       <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            lse_q     <= '0;
            ready_en  <= 1'b0;
            len_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            len_err  <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_hs) begin
                        count   <= count + 1'b1;
                        len_err <= trunc;
                        if (count == '0 || in_data > max_q) max_q <= in_data;
                    end
                end
                SUM: begin
                    sum_q <= sum_q + e;
                    idx   <= last_idx ? '0 : idx + 1'b1;
                end
                LOG: begin
                    lse_q <= L2_W'(lse_prod >> FRAC_W);
                    idx   <= '0;
                end
                EMIT: begin
                    if (out_hs && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        count     <= '0;
                        sum_q     <= '0;
                        idx       <= '0;
                    end else if (!(out_valid && out_last) && (!out_valid || out_ready)) begin
                        out_valid <= 1'b1;
                        out_data  <= DATA_W'(y_sat);
                        out_last  <= last_idx;
                        idx       <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_log_softmax_stream.sv
// tb/tb_log_softmax_stream.sv - scoreboard bench for log_softmax_stream
`timescale 1ns/1ps
module tb_log_softmax_stream;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int MAX_LEN = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;
    logic                     busy;
    logic                     len_err;

    log_softmax_stream #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_data[$];
    bit exp_last[$];
    int stim[$];
    int cyc = 0;
    int hs_count = 0;
    int err_at = -1;
    int len_err_seen = 0;
    int first_valid_cyc = 0;
    int last_hs_cyc = 0;
    bit rand_ready = 1'b0;
    bit force_stall = 1'b0;
    logic prev_valid = 1'b0;
    logic stall_prev = 1'b0;
    logic [DATA_W:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (force_stall)     out_ready = 1'b0;
        else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = 1'b1;
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic bail(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no progress expected completion within bound", what);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Monitor: pops the scoreboard on every output handshake, checks hold-while-stalled
    always @(negedge clk) begin
        int  ed;
        bit  el;
        if (!rst) begin
            if (len_err) begin
                len_err_seen++;
                err_at = hs_count;
            end
            if (out_valid && !prev_valid) first_valid_cyc = cyc;
            if (stall_prev && out_valid) check("stall_hold", int'({out_last, out_data}), int'(held));
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected none", out_data);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    check("out_data", int'(out_data), ed);
                    check("out_last", int'(out_last), int'(el));
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_data};
            prev_valid = out_valid;
        end else begin
            stall_prev = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic push_exp(input int v, input bit l);
        exp_data.push_back(v);
        exp_last.push_back(l);
    endtask

    // Reference: integer formulas written directly from the algorithm description
    task automatic model_push();
        int mx, s, p, l2, lse, d, t, k, f, ev, y;
        mx = stim[0];
        foreach (stim[i]) if (stim[i] > mx) mx = stim[i];
        s = 0;
        foreach (stim[i]) begin
            d  = stim[i] - mx;
            t  = (d * 369) >>> 8;
            k  = t >>> 8;
            f  = t - k * 256;
            ev = (-k >= 15) ? 0 : ((256 + f) >> (-k));
            s  = s + ev;
        end
        p = 0;
        while ((2 << p) <= s) p++;
        l2  = (p - 8) * 256 + ((s - (1 << p)) >> (p - 8));
        lse = (l2 * 177) >>> 8;
        foreach (stim[i]) begin
            y = stim[i] - mx - lse;
            if (y < -32768) y = -32768;
            push_exp(y, i == stim.size() - 1);
        end
    endtask

    task automatic drive_stim();
        int g;
        for (int i = 0; i < stim.size(); i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(stim[i]);
            in_last  = (i == stim.size() - 1);
            g = 0;
            @(negedge clk);
            while (!in_ready) begin
                g++;
                if (g > 2000) bail("in_ready");
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            hs_count++;
            last_hs_cyc = cyc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_data.size() != 0 || busy) begin
            @(negedge clk);
            g++;
            if (g > 3000) bail("drain");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_len_err", int'(len_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("rst_in_ready_high", int'(in_ready), 1);

        // N=4 of 1.0: lse=354, latency N+2
        stim = '{256, 256, 256, 256};
        for (int i = 0; i < 4; i++) push_exp(-354, i == 3);
        drive_stim();
        wait_drain();
        check("latency_n4", first_valid_cyc - last_hs_cyc, 6);

        // Reset while stalled in EMIT aborts the vector
        force_stall = 1'b1;
        stim = '{100, 200, 300};
        drive_stim();
        g = 0;
        while (!out_valid) begin
            @(posedge clk);
            #1;
            g++;
            if (g > 200) bail("emit_before_reset");
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        check("midrst_in_ready_high", int'(in_ready), 1);
        force_stall = 1'b0;
        stim = '{0, 0};
        push_exp(-177, 1'b0);
        push_exp(-177, 1'b1);
        drive_stim();
        wait_drain();

        // N=2 [1.0, 0]
        stim = '{256, 0};
        push_exp(-68, 1'b0);
        push_exp(-324, 1'b1);
        drive_stim();
        wait_drain();

        // N=1 collapses to zero
        stim = '{-5000};
        push_exp(0, 1'b1);
        drive_stim();
        wait_drain();

        // Extremes: far-below element saturates
        stim = '{32767, -32768};
        push_exp(0, 1'b0);
        push_exp(-32768, 1'b1);
        drive_stim();
        wait_drain();

        // 70 zeros with in_last only on the 70th: truncated at 64, then a 6-element vector
        hs_count     = 0;
        len_err_seen = 0;
        stim.delete();
        for (int i = 0; i < 70; i++) stim.push_back(0);
        for (int i = 0; i < 64; i++) push_exp(-1062, i == 63);
        for (int i = 0; i < 6; i++)  push_exp(-442, i == 5);
        drive_stim();
        wait_drain();
        check("len_err_pulses", len_err_seen, 1);
        check("len_err_position", err_at, 64);

        // Random 32-element vectors under random backpressure
        rand_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            stim.delete();
            for (int i = 0; i < 32; i++) begin
                if (v == 0) stim.push_back(int'($urandom_range(0, 65535)) - 32768);
                else        stim.push_back(int'($urandom_range(0, 2047)) - 1024);
            end
            if (v == 1) begin
                stim[5]  = -32768;
                stim[20] = 32767;
            end
            model_push();
            drive_stim();
            wait_drain();
        end
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/log_softmax_stream.md
Name: log_softmax_stream

Overview:
- Streaming, parametrised LogSoftmax over variable-length vectors of signed fixed-point elements. Computes y_i = x_i - max - ln(sum_j exp(x_j - max)).
- Exp and log use fully specified shift/linear (Mitchell-style) approximations, so results are bit-exact and reproducible in the reference model.
- Sits between producer and consumer stages of the activation datapath. Uses valid/ready handshakes and a tlast-style delimiter.
- Single-buffered: load, reduce, then emit; the phases do not overlap.

Parameters:
- DATA_W, 16, element width, signed two's complement.
- FRAC_W, 8, fractional bits of input and output (Q(DATA_W-FRAC_W).FRAC_W).
- MAX_LEN, 64, maximum vector length (2..256); sets buffer depth.
- SUM_W, FRAC_W+1+$clog2(MAX_LEN), exp-sum accumulator width (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts an input element.
- in_data  in  DATA_W  input element x_i.
- in_last  in  1  marks the final element of a vector.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts the output element.
- out_data  out  DATA_W  output element y_i.
- out_last  out  1  marks the final output element of a vector.
- busy  out  1  high in any state other than LOAD, or in LOAD while count>0.
- len_err  out  1  one-cycle pulse when a vector is truncated at MAX_LEN.

Behaviour:
- Reset (rst=1 at an edge): state=LOAD, count=0, max cleared, sum=0. Outputs: in_ready=0 during the reset cycle, then 1. out_valid=0, out_data=0, out_last=0, len_err=0. Buffer contents are not cleared.
- Reset mid-operation aborts the current vector; no partial output follows.
- States: LOAD -> SUM -> LOG -> EMIT -> LOAD.
- LOAD:
  - in_ready=1; handshake = in_valid & in_ready.
  - Each handshake: buf[count]=in_data, count+=1. max = in_data on the first element, otherwise signed max.
  - Handshake with in_last=1 -> SUM.
  - Handshake at count==MAX_LEN-1 with in_last=0 -> element treated as last, len_err pulses, go to SUM. Any trailing elements of that vector belong to the next vector.
- SUM:
  - One element per cycle, idx 0..N-1 (N = count). All arithmetic is exact integer; >>> is arithmetic shift.
  - d = buf[idx] - max, DATA_W+1 bits, always <= 0.
  - t = (d*LOG2E_Q) >>> FRAC_W.
  - k = t >>> FRAC_W, f = t - (k<<FRAC_W).
  - e = ((1<<FRAC_W)+f) >> (-k); e=0 if -k >= SUM_W.
  - sum += e. Takes N cycles, then -> LOG.
- LOG (1 cycle):
  - p = index of the leading one of sum (sum >= 1<<FRAC_W always).
  - L2 = ((p-FRAC_W)<<FRAC_W) + ((sum - (1<<p)) >> (p-FRAC_W)).
  - lse = (L2*LN2_Q) >> FRAC_W, registered. -> EMIT.
- EMIT:
  - out_data = saturate_DATA_W(buf[idx] - max - lse), clamped to -2^(DATA_W-1).
  - out_last=1 when idx==N-1.
  - While out_valid & !out_ready, out_data and out_last are held stable.
  - Handshake on last element -> LOAD, count=0, sum=0.
- Latency: first out_valid is asserted exactly N+2 cycles after the in_last handshake cycle. Throughput is one output per cycle under full out_ready.
- in_ready=0 in SUM, LOG and EMIT.
- N=1 edge case: sum=1<<FRAC_W, lse=0, output 0.

Decomposition:
- Package log_softmax_pkg:
  - state enum {LOAD,SUM,LOG,EMIT}.
  - LOG2E_Q = round(log2(e)*2^FRAC_W) (369 @FRAC_W=8).
  - LN2_Q = round(ln2*2^FRAC_W) (177 @FRAC_W=8).
  - Saturation helper function.
- Sub-module lsm_exp2_log2: purely combinational, holding the exp2 term path (d -> e) and the Mitchell log2 path (sum -> L2). The top level keeps the FSM, buffer, counters and handshakes.

Test Plan:
- Reset mid-EMIT -> out_valid=0 next cycle, in_ready=1 one cycle after rst deasserts. A fresh vector [0,0] then emits [-177,-177]: sum=512, L2=256, lse=177.
- N=4, all x=0x0100 -> sum=1024, L2=512, lse=354. Outputs [-354,-354,-354,-354], out_last on the 4th, first out_valid 6 cycles after the last handshake.
- N=2, x=[256,0] -> e1=99, sum=355, L2=99, lse=68. Outputs [-68,-324].
- N=1, x=-5000 -> output 0, out_last=1.
- MAX_LEN=64, stream of 70 elements with in_last only on the 70th -> len_err pulse at element 64. A 64-element vector is emitted, then a 6-element vector.
- Random out_ready toggling (50%) on 32-element random vectors -> outputs stable while stalled, bit-exact vs model. Extreme-negative input saturates to -32768.
